// File: rtl/cpu_types_pkg.sv
// Shared CPU-wide scalar types used by the datapath and cache interfaces.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;
endpackage

// File: rtl/fetch_pkg.sv
// Types shared between the fetch queue and its ring buffer.
package fetch_pkg;
  import cpu_types_pkg::*;

  typedef struct packed {
    word_t inst;
    word_t pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ring_buffer.sv
// Circular queue of fetched {instruction, PC} entries with flush.
module fetch_ring_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push,
  input  fetch_entry_t     pushData,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     headData,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] headPtr;
  logic [PTR_W-1:0] tailPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full && !flush;
  assign doPop    = pop && !empty && !flush;
  assign headData = mem[headPtr];

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (doPush) tailPtr <= tailPtr + PTR_W'(1);
      if (doPop)  headPtr <= headPtr + PTR_W'(1);
      if (doPush && !doPop)
        count <= count + CNT_W'(1);
      else if (doPop && !doPush)
        count <= count - CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (doPush) mem[tailPtr] <= pushData;
  end

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential PC generation feeding a ring buffer,
// with redirect-and-flush and a sticky halt.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int          DEPTH   = 4,
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter logic [31:0] PC_INC  = 32'd4,
  localparam int         CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  output logic             imemREN,
  output logic [31:0]      imemaddr,
  input  logic             ihit,
  input  logic [31:0]      imemload,
  input  logic             deq,
  output logic             valid,
  output logic [31:0]      inst_out,
  output logic [31:0]      inst_pc,
  input  logic             redirect,
  input  logic [31:0]      redirect_pc,
  input  logic             halt,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  logic [31:0]  fetchPc;
  logic         haltQ;
  logic         fetchAcc;
  logic         empty;
  fetch_entry_t newEntry;
  fetch_entry_t headEntry;

  assign imemaddr = fetchPc;
  assign imemREN  = !halt && !haltQ && !full;
  assign fetchAcc = ihit && imemREN && !redirect;
  assign newEntry = {imemload, fetchPc};
  assign valid    = !empty;
  assign inst_out = valid ? headEntry.inst : 32'h0;
  assign inst_pc  = valid ? headEntry.pc : 32'h0;

  fetch_ring_buffer #(.DEPTH(DEPTH)) ring (
    .CLK      (CLK),
    .RST      (RST),
    .push     (fetchAcc),
    .pushData (newEntry),
    .pop      (deq),
    .flush    (redirect),
    .headData (headEntry),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  // Redirect wins over a concurrent hit; the hit data is simply dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetchPc <= PC_INIT;
      haltQ   <= 1'b0;
    end else begin
      if (redirect)
        fetchPc <= redirect_pc;
      else if (fetchAcc)
        fetchPc <= fetchPc + PC_INC;
      if (halt) haltQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: DEPTH=4 and DEPTH=8 instances on shared stimulus,
// checked every cycle against a queue-based reference plus literal spot checks.
module tb_fetch_queue;
  logic        CLK = 1'b0;
  logic        RST, ihit, deq, redirect, halt;
  logic [31:0] imemload, redirect_pc;

  logic        ren0, ren1, v0, v1, f0, f1;
  logic [31:0] addr0, addr1, io0, io1, ip0, ip1;
  logic [2:0]  cnt0;
  logic [3:0]  cnt1;

  fetch_queue #(.DEPTH(4)) dut0 (
    .CLK(CLK), .RST(RST), .imemREN(ren0), .imemaddr(addr0), .ihit(ihit),
    .imemload(imemload), .deq(deq), .valid(v0), .inst_out(io0), .inst_pc(ip0),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .count(cnt0), .full(f0)
  );

  fetch_queue #(.DEPTH(8)) dut1 (
    .CLK(CLK), .RST(RST), .imemREN(ren1), .imemaddr(addr1), .ihit(ihit),
    .imemload(imemload), .deq(deq), .valid(v1), .inst_out(io1), .inst_pc(ip1),
    .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .count(cnt1), .full(f1)
  );

  always #5 CLK = ~CLK;

  int          checks   = 0;
  int          failures = 0;
  int          ld       = 0;
  logic [63:0] mq [2][$];
  logic [31:0] mpc [2];
  logic        mh [2];
  int          dep [2] = '{4, 8};
  logic        started = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a plain queue of {inst, pc} plus the next fetch address.
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      logic ren;
      if (RST) begin
        mq[k].delete();
        mpc[k] = 32'h0;
        mh[k]  = 1'b0;
      end else begin
        ren = !halt && !mh[k] && (mq[k].size() < dep[k]);
        if (redirect) begin
          mq[k].delete();
          mpc[k] = redirect_pc;
        end else begin
          if (deq && mq[k].size() > 0) void'(mq[k].pop_front());
          if (ihit && ren) begin
            mq[k].push_back({imemload, mpc[k]});
            mpc[k] = mpc[k] + 32'd4;
          end
        end
        if (halt) mh[k] = 1'b1;
      end
    end
    if (RST) started = 1'b1;
  end

  task automatic cmpOne(input int k, input logic v, input logic [31:0] c, input logic f,
                        input logic ren, input logic [31:0] a, input logic [31:0] io,
                        input logic [31:0] ip);
    int   n;
    logic ev, ef;
    n  = mq[k].size();
    ev = (n != 0);
    ef = (n == dep[k]);
    chk($sformatf("d%0d.valid", k), v, ev);
    chk($sformatf("d%0d.count", k), c, n);
    chk($sformatf("d%0d.full", k), f, ef);
    chk($sformatf("d%0d.imemREN", k), ren, !halt && !mh[k] && !ef);
    chk($sformatf("d%0d.imemaddr", k), a, mpc[k]);
    chk($sformatf("d%0d.inst_out", k), io, ev ? mq[k][0][63:32] : 32'h0);
    chk($sformatf("d%0d.inst_pc", k), ip, ev ? mq[k][0][31:0] : 32'h0);
  endtask

  always @(negedge CLK) begin
    if (started) begin
      cmpOne(0, v0, 32'(cnt0), f0, ren0, addr0, io0, ip0);
      cmpOne(1, v1, 32'(cnt1), f1, ren1, addr1, io1, ip1);
    end
  end

  task automatic step(input logic r, input logic ih, input logic dq, input logic rd,
                      input logic hl, input logic [31:0] rpc);
    RST = r; ihit = ih; deq = dq; redirect = rd; halt = hl; redirect_pc = rpc;
    imemload = 32'hC0DE_0000 + 32'(ld);
    ld++;
    @(negedge CLK);
    #1;
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("rst.count", 32'(cnt0), 0);
    chk("rst.valid", v0, 0);
    chk("rst.imemREN", ren0, 1);
    chk("rst.imemaddr", addr0, 32'h0);
    chk("rst.inst_out", io0, 32'h0);

    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    chk("fill.count", 32'(cnt0), 4);
    chk("fill.full", f0, 1);
    chk("fill.imemREN", ren0, 0);
    chk("fill.imemaddr", addr0, 32'h10);
    chk("fill.head_pc", ip0, 32'h0);
    chk("model.fill_size", mq[0].size(), 4);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("full_hit.count", 32'(cnt0), 4);
    chk("full_hit.imemaddr", addr0, 32'h10);

    step(0, 1, 1, 0, 0, 0);
    chk("pop_full.count", 32'(cnt0), 3);
    chk("pop_full.full", f0, 0);
    chk("pop_full.imemREN", ren0, 1);
    chk("pop_full.head_pc", ip0, 32'h4);
    chk("pop_full.imemaddr", addr0, 32'h10);

    step(0, 0, 1, 0, 0, 0);
    chk("pop.count", 32'(cnt0), 2);
    step(0, 1, 1, 0, 0, 0);
    chk("pushpop.count", 32'(cnt0), 2);
    chk("pushpop.head_pc", ip0, 32'hC);
    chk("pushpop.imemaddr", addr0, 32'h14);
    chk("model.pushpop_tail_pc", mq[0][1][31:0], 32'h10);

    step(0, 1, 0, 0, 0, 0);
    chk("pre_redir.count", 32'(cnt0), 3);
    step(0, 1, 0, 1, 0, 32'h200);
    chk("redir.count", 32'(cnt0), 0);
    chk("redir.valid", v0, 0);
    chk("redir.imemaddr", addr0, 32'h200);
    chk("redir.imemREN", ren0, 1);
    chk("redir.inst_out", io0, 32'h0);

    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    chk("refill.count", 32'(cnt0), 3);
    chk("refill.head_pc", ip0, 32'h200);
    step(0, 1, 0, 0, 1, 0);
    chk("halt.count", 32'(cnt0), 3);
    chk("halt.imemREN", ren0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 0, 0, 0);
      chk("halt_drain.imemREN", ren0, 0);
    end
    chk("halt_drain.count", 32'(cnt0), 0);
    step(0, 0, 0, 1, 0, 32'h40);
    chk("halt_redir.imemaddr", addr0, 32'h40);
    chk("halt_redir.imemREN", ren0, 0);

    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, 0, 0, 0);
    chk("d8.fill.count", 32'(cnt1), 8);
    chk("d8.fill.full", f1, 1);
    step(1, 1, 0, 0, 0, 0);
    chk("d8.rst.count", 32'(cnt1), 0);
    chk("d8.rst.valid", v1, 0);
    chk("d8.rst.inst_out", io1, 32'h0);
    chk("d8.rst.imemaddr", addr1, 32'h0);
    chk("d8.rst.imemREN", ren1, 1);

    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      chk("wrap.d8.pc", ip1, 32'(i * 4));
      chk("wrap.d4.pc", ip0, 32'(i * 4));
      step(0, 1, 1, 0, 0, 0);
    end
    chk("wrap.d8.last_pc", ip1, 32'h20);
    step(0, 0, 1, 0, 0, 0);
    chk("wrap.d8.count", 32'(cnt1), 0);
    chk("wrap.d8.imemaddr", addr1, 32'h24);

    step(0, 0, 0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Parametrised instruction-fetch front end that decouples PC sequencing from instruction consumption. It holds a DEPTH-entry circular queue of fetched {instruction, PC} pairs. It issues sequential fetches to the instruction side of the cache interface whenever space exists. It sits between the icache port of datapath_cache_if and the decode/control stage, and supports branch/jump redirect-with-flush and sticky halt.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
PC_INIT, 0, fetch PC after reset
PC_INC, 4, byte increment between sequential fetches

Ports:
CLK  input  1  clock, rising edge
RST  input  1  reset; synchronous, active-high
imemREN  output  1  instruction read request to cache
imemaddr  output  32  fetch address (word_t)
ihit  input  1  cache: imemload valid for current imemaddr this cycle
imemload  input  32  fetched instruction
deq  input  1  consumer pops head entry
valid  output  1  queue non-empty; head outputs meaningful
inst_out  output  32  head instruction; 0 when empty
inst_pc  output  32  PC of head instruction; 0 when empty
redirect  input  1  flush queue, restart fetch at redirect_pc
redirect_pc  input  32  new fetch PC (word-aligned by producer)
halt  input  1  stop fetching; sticky until RST
count  output  $clog2(DEPTH+1)  occupied entries
full  output  1  count == DEPTH

Behaviour:
- State: fetch_pc, head/tail pointers (log2 DEPTH bits, wrap modulo DEPTH), count, halt_q, storage array.
- Reset (RST high at a clock edge, any state): count=0, pointers=0, fetch_pc=PC_INIT, halt_q=0, storage contents don't-care.
- Post-reset outputs: valid=0, full=0, count=0, inst_out=0, inst_pc=0, imemaddr=PC_INIT, imemREN=1.
- imemaddr = fetch_pc, always driven.
- imemREN = !halt && !halt_q && !full. Combinational; depends only on registered state and halt.
- Accepted fetch: ihit && imemREN && !redirect.
  - Writes {imemload, fetch_pc} at tail; tail += 1; fetch_pc += PC_INC (32-bit wrap).
  - ihit with imemREN low is ignored.
- Accepted pop: deq && valid && !redirect; head += 1. deq while empty is ignored, with no pointer change.
- Count update: +1 on fetch only, -1 on pop only, unchanged when both occur or neither.
- Latency: fetch accepted at cycle t makes the entry visible at head (valid=1) at t+1. There is no bypass.
- Full: no fetch possible because imemREN is low. A pop while full lowers full next cycle and re-raises imemREN.
- Redirect has priority over fetch and pop in the same cycle:
  - next cycle count=0, head=tail=0, fetch_pc=redirect_pc;
  - any concurrent ihit data is discarded.
- Halt: halt_q <= 1 when halt is high; cleared only by RST.
  - While halt or halt_q is high, imemREN=0.
  - Existing entries still drain via deq.
  - redirect still flushes and loads fetch_pc.
- Address stability: while imemREN=1 and no ihit/redirect occurs, imemaddr is held constant.
- Simultaneous RST with any input: reset wins.

Decomposition:
- New package fetch_pkg, importing cpu_types_pkg:
  - typedef fetch_entry_t, a packed struct {word_t inst; word_t pc};
  - localparam FETCH_PTR_W = $clog2(DEPTH) is computed in the module, not the package.
- One natural sub-module: fetch_ring_buffer.
  - Parametrised by DEPTH; owns storage, pointers, count, full/empty.
  - Ports: push/push_data, pop, flush, head_data, count.
- fetch_queue adds fetch_pc sequencing, imemREN gating, redirect and halt.

Test Plan:
- RST, then ihit=1 every cycle, deq=0 -> entries with PCs 0x0, 0x4, 0x8, 0xC; full=1 after 4th hit; imemREN=0; imemaddr holds 0x10.
- From full, deq=1 for one cycle -> next cycle count=3, full=0, imemREN=1, inst_pc=0x4; ihit=1 while imemREN=0 is never enqueued.
- count=2, deq=1 and ihit=1 same cycle -> count stays 2; head advances by one; new entry PC = previous fetch_pc; imemaddr += 4.
- count=3, redirect=1 with redirect_pc=0x200 and ihit=1 same cycle -> next cycle count=0, valid=0, imemaddr=0x200, imemREN=1; the hit data is absent from the queue.
- halt=1 pulse with ihit=1 same cycle -> no enqueue; imemREN=0 from that cycle until RST; remaining entries drain with deq; redirect to 0x40 gives imemaddr=0x40 with imemREN still 0.
- Queue full with DEPTH=8 build, RST=1 for one cycle -> count=0, valid=0, inst_out=0, imemaddr=PC_INIT, imemREN=1; after 9 hits and 9 pops, pointers wrap and PCs stay in order 0x0..0x20.
